// File: rtl/mem_access.sv
// Memory-access stage: single-outstanding req/ack bus, load alignment/extension, store lane steering.
// Optional feature macro: MEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of truncating.
module mem_access (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        valid_in,
  input  logic        is_load_store,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        stall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [1:0]  fsm_state
);

  // Handshake: bus_req rises the cycle after acceptance and stays high, with
  // we/addr/be/wdata stable, until the cycle bus_ack is sampled high; the
  // transaction then completes and bus_req drops at that same edge.

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  state_t      state;
  logic [5:0]  opcode;
  logic [1:0]  offset;
  logic        is_load;
  logic        is_store;
  logic        load_signed;
  size_t       size;
  logic        mem_op;
  logic        trap;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic        ld_store;
  size_t       ld_size;
  logic        ld_signed;
  logic [1:0]  ld_offset;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_value;
  logic        unused_ins;

  assign opcode     = ins[31:26];
  assign offset     = alu_result[1:0];
  assign unused_ins = ^ins[25:0];
  assign fsm_state  = state;

  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    load_signed = 1'b0;
    size        = SZ_WORD;
    case (opcode)
      OP_LB:  begin is_load  = 1'b1; load_signed = 1'b1; size = SZ_BYTE; end
      OP_LH:  begin is_load  = 1'b1; load_signed = 1'b1; size = SZ_HALF; end
      OP_LW:  begin is_load  = 1'b1; size = SZ_WORD; end
      OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  // Unsupported opcodes with is_load_store set fall out as no-op pass-through.
  assign mem_op = valid_in && is_load_store && (is_load || is_store);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op && (((size == SZ_HALF) && offset[0]) ||
                           ((size == SZ_WORD) && (offset != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // Lane steering; loads reuse the same byte-enable pattern as stores.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data;
    case (size)
      SZ_BYTE: begin
        be_next    = 4'b0001 << offset;
        wdata_next = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be_next    = offset[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_offset)
      2'd0:    sel_byte = bus_rdata[7:0];
      2'd1:    sel_byte = bus_rdata[15:8];
      2'd2:    sel_byte = bus_rdata[23:16];
      default: sel_byte = bus_rdata[31:24];
    endcase
    sel_half = ld_offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_size)
      SZ_BYTE: load_value = {{24{ld_signed & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_value = {{16{ld_signed & sel_half[15]}}, sel_half};
      default: load_value = bus_rdata;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    stall = mem_op;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      wb_data   <= '0;
      wb_valid  <= 1'b0;
      ld_store  <= 1'b0;
      ld_size   <= SZ_WORD;
      ld_signed <= 1'b0;
      ld_offset <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign  <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (trap) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign <= 1'b1;
`endif
          end else if (mem_op) begin
            state     <= BUSY;
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {alu_result[31:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            ld_store  <= is_store;
            ld_size   <= size;
            ld_signed <= load_signed;
            ld_offset <= offset;
          end else if (valid_in) begin
            wb_valid <= 1'b1;
            wb_data  <= is_load_store ? 32'h0 : alu_result;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state    <= DONE;
            bus_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= ld_store ? 32'h0 : load_value;
          end
        end
        DONE: begin
          // The held memory instruction retires here; only a non-memory
          // instruction presented now is passed through.
          state <= IDLE;
          if (valid_in && !mem_op) begin
            wb_valid <= 1'b1;
            wb_data  <= is_load_store ? 32'h0 : alu_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: spec-level model feeding expected queues, checked every cycle.
module tb_mem_access;

  localparam logic [5:0] LB   = 6'h20;
  localparam logic [5:0] LH   = 6'h21;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] LBU  = 6'h24;
  localparam logic [5:0] LHU  = 6'h25;
  localparam logic [5:0] SB   = 6'h28;
  localparam logic [5:0] SH   = 6'h29;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] ADDU = 6'h00;
  localparam logic [5:0] NOPM = 6'h2F;

  logic        sys_clk;
  logic        rst_n;
  logic [31:0] ins;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        valid_in;
  logic        is_load_store;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic        stall;
  logic [1:0]  fsm_state;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  mem_access dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .ins(ins), .alu_result(alu_result),
    .store_data(store_data), .valid_in(valid_in), .is_load_store(is_load_store),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_data(wb_data), .wb_valid(wb_valid), .stall(stall),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [68:0] exp_bus_q[$];   // {we, be[3:0], addr[31:0], wdata[31:0]}
  logic [32:0] exp_wb_q[$];    // {misalign, wb_data}
  int          req_count = 0;
  int          wb_count  = 0;
  logic [31:0] last_addr, last_wdata, last_wb;
  logic [3:0]  last_be;
  logic        last_we, last_mis;
  logic        prev_req = 1'b0;
  logic [68:0] held_bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level model: access width in bytes, natural lane base, replicated data.
  function automatic void predict(input logic [5:0] op, input logic ls,
                                  input logic [31:0] alu, input logic [31:0] sd,
                                  input logic [31:0] rd, output logic mem,
                                  output logic trap, output logic [68:0] eb,
                                  output logic [32:0] ew);
    int nbytes, a, base;
    logic is_ld, is_st, sgn;
    logic [7:0]  bemask;
    logic [31:0] wd, mask, v;
    is_ld = ls && (op inside {LB, LH, LW, LBU, LHU});
    is_st = ls && (op inside {SB, SH, SW});
    mem   = is_ld || is_st;
    trap  = 1'b0;
    eb    = '0;
    if (!mem) begin
      ew = {1'b0, (ls ? 32'h0 : alu)};
      return;
    end
    if (op == LB || op == LBU || op == SB) nbytes = 1;
    else if (op == LH || op == LHU || op == SH) nbytes = 2;
    else nbytes = 4;
    sgn  = (op == LB) || (op == LH);
    a    = int'(alu[1:0]);
    base = a - (a % nbytes);
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (a % nbytes) != 0;
`endif
    if (trap) begin
      ew = {1'b1, 32'h0};
      return;
    end
    bemask = ((8'h1 << nbytes) - 8'h1) << base;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % nbytes) +: 8];
    eb = {is_st, bemask[3:0], alu[31:2], 2'b00, wd};
    if (is_st) begin
      ew = {1'b0, 32'h0};
    end else begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nbytes)) - 32'h1);
      v = (rd >> (8*base)) & mask;
      if (sgn && v[8*nbytes-1]) v = v | ~mask;
      ew = {1'b0, v};
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(posedge sys_clk) begin
    logic [68:0] e;
    logic [32:0] w;
    #1;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus_req && !prev_req) begin
        req_count++;
        last_addr = bus_addr; last_be = bus_be; last_wdata = bus_wdata; last_we = bus_we;
        held_bus = {bus_we, bus_be, bus_addr, bus_wdata};
        if (exp_bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_req: unexpected request addr=%0h expected no request", bus_addr);
        end else begin
          e = exp_bus_q.pop_front();
          check("bus_we", 32'(bus_we), 32'(e[68]));
          check("bus_be", 32'(bus_be), 32'(e[67:64]));
          check("bus_addr", bus_addr, e[63:32]);
          if (e[68]) check("bus_wdata", bus_wdata, e[31:0]);
        end
      end else if (bus_req) begin
        check("bus_hold_addr", bus_addr, held_bus[63:32]);
        check("bus_hold_be", 32'(bus_be), 32'(held_bus[67:64]));
        check("bus_hold_we", 32'(bus_we), 32'(held_bus[68]));
      end
      prev_req = bus_req;
      if (wb_valid) begin
        wb_count++;
        last_wb = wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
        last_mis = misalign;
`else
        last_mis = 1'b0;
`endif
        if (exp_wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_valid: unexpected pulse data=%0h expected none", wb_data);
        end else begin
          w = exp_wb_q.pop_front();
          check("wb_data", wb_data, w[31:0]);
`ifdef MEM_MISALIGN_TRAP_EN
          check("misalign", 32'(misalign), 32'(w[32]));
`endif
        end
      end
`ifdef MEM_MISALIGN_TRAP_EN
      else check("misalign_quiet", 32'(misalign), 32'd0);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [5:0] op, input logic ls, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] rd, input int ack_after,
                       output int stalls);
    logic mem, trap;
    logic [68:0] eb;
    logic [32:0] ew;
    int req_cycles, exp_stalls;
    predict(op, ls, alu, sd, rd, mem, trap, eb, ew);
    if (mem && !trap) exp_bus_q.push_back(eb);
    exp_wb_q.push_back(ew);
    exp_stalls = !mem ? 0 : (trap ? 1 : ack_after + 1);
    stalls = 0;
    req_cycles = 0;
    @(negedge sys_clk);
    ins = {op, 26'h0};
    alu_result = alu;
    store_data = sd;
    is_load_store = ls;
    valid_in = 1'b1;
    forever begin
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        req_cycles++;
        if (req_cycles == ack_after) begin
          bus_ack = 1'b1;
          bus_rdata = rd;
        end
      end
      #1;
      if (!stall) break;
      stalls++;
      if (stalls > 40) begin
        checks++; errors++;
        $display("FAIL stall_timeout: stall still high after %0d cycles expected %0d", stalls, exp_stalls);
        break;
      end
      @(negedge sys_clk);
    end
    check("stall_cycles", stalls, exp_stalls);
    @(posedge sys_clk);
    #2;
    valid_in = 1'b0;
    is_load_store = 1'b0;
    bus_ack = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int st, n0, r0;
    logic m, t;
    logic [68:0] eb;
    logic [32:0] ew;
    rst_n = 1'b0; ins = '0; alu_result = '0; store_data = '0; valid_in = 1'b0;
    is_load_store = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Pin the model against hand-derived values.
    predict(LB, 1'b1, 32'h1003, 32'h0, 32'h80AB_CDEF, m, t, eb, ew);
    check("model_lb", ew[31:0], 32'hFFFF_FF80);
    predict(SH, 1'b1, 32'h1002, 32'h1234_5678, 32'h0, m, t, eb, ew);
    check("model_sh_be", 32'(eb[67:64]), 32'hC);
    check("model_sh_wdata", eb[31:0], 32'h5678_5678);

    n0 = wb_count;
    issue(SW, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 2, st);
    check("sw_stall", st, 32'd3);
    check("sw_addr", last_addr, 32'h1008);
    check("sw_be", 32'(last_be), 32'hF);
    check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    check("sw_we", 32'(last_we), 32'd1);
    check("sw_wb", last_wb, 32'h0);
    check("sw_wb_count", wb_count - n0, 32'd1);

    issue(LB, 1'b1, 32'h1003, 32'h0, 32'h80AB_CDEF, 1, st);
    check("lb_be", 32'(last_be), 32'h8);
    check("lb_wb", last_wb, 32'hFFFF_FF80);
    issue(LBU, 1'b1, 32'h1003, 32'h0, 32'h80AB_CDEF, 1, st);
    check("lbu_wb", last_wb, 32'h0000_0080);

    issue(SH, 1'b1, 32'h1002, 32'h1234_5678, 32'h0, 3, st);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wdata, 32'h5678_5678);
    issue(LHU, 1'b1, 32'h1002, 32'h0, 32'hF00D_0000, 3, st);
    check("lhu_wb", last_wb, 32'h0000_F00D);

    n0 = wb_count;
    issue(ADDU, 1'b0, 32'h55, 32'h0, 32'h0, 1, st);
    check("addu_stall", st, 32'd0);
    check("addu_wb", last_wb, 32'h55);
    issue(LW, 1'b1, 32'h2000, 32'h0, 32'hCAFE_F00D, 1, st);
    check("addu_lw_wb", last_wb, 32'hCAFE_F00D);
    check("addu_lw_count", wb_count - n0, 32'd2);

    issue(LH, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 2, st);
    check("lh_hi_wb", last_wb, 32'hFFFF_8001);
    issue(LH, 1'b1, 32'h2000, 32'h0, 32'h8001_1234, 1, st);
    check("lh_lo_wb", last_wb, 32'h0000_1234);
    issue(SB, 1'b1, 32'h3001, 32'h0000_00A5, 32'h0, 1, st);
    check("sb_be", 32'(last_be), 32'h2);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);

    r0 = req_count;
    issue(NOPM, 1'b1, 32'h77, 32'h0, 32'h0, 1, st);
    check("nopm_wb", last_wb, 32'h0);
    check("nopm_no_req", req_count - r0, 32'd0);

    r0 = req_count;
    issue(LW, 1'b1, 32'h1002, 32'h0, 32'h1122_3344, 1, st);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_no_req", req_count - r0, 32'd0);
    check("mis_stall", st, 32'd1);
    check("mis_flag", 32'(last_mis), 32'd1);
    check("mis_wb", last_wb, 32'h0);
`else
    check("lw_unal_addr", last_addr, 32'h1000);
    check("lw_unal_be", 32'(last_be), 32'hF);
    check("lw_unal_wb", last_wb, 32'h1122_3344);
`endif

    // An ack with nothing outstanding must be ignored.
    n0 = wb_count; r0 = req_count;
    @(negedge sys_clk); bus_ack = 1'b1; bus_rdata = 32'h1234_4321;
    @(negedge sys_clk); bus_ack = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("idle_ack_wb", wb_count - n0, 32'd0);
    check("idle_ack_state", 32'(fsm_state), 32'd0);
    check("idle_ack_req", req_count - r0, 32'd0);

    // Reset while a load is outstanding.
    n0 = wb_count; r0 = req_count;
    predict(LW, 1'b1, 32'h3000, 32'h0, 32'h0, m, t, eb, ew);
    exp_bus_q.push_back(eb);
    @(negedge sys_clk);
    ins = {LW, 26'h0}; alu_result = 32'h3000; is_load_store = 1'b1; valid_in = 1'b1;
    @(negedge sys_clk);
    #1;
    check("busy_req", 32'(bus_req), 32'd1);
    check("busy_state", 32'(fsm_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(bus_req), 32'd0);
    check("rst_state_idle", 32'(fsm_state), 32'd0);
    valid_in = 1'b0; is_load_store = 1'b0;
    @(negedge sys_clk); rst_n = 1'b1;
    @(negedge sys_clk); bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    @(negedge sys_clk); bus_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_no_wb", wb_count - n0, 32'd0);
    check("rst_late_state", 32'(fsm_state), 32'd0);
    check("rst_one_req", req_count - r0, 32'd1);
    check("rst_req_low", 32'(bus_req), 32'd0);

    check("exp_bus_empty", exp_bus_q.size(), 32'd0);
    check("exp_wb_empty", exp_wb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
